exp_table_loader: RTL and testbench
===================================

Name: exp_table_loader

Overview:
- Upstream fill stage for the FP32 exp lookup tables. The exp block reads two SRAMs: hi table (16b index, {E_adj, M_hi, S}) and lo table (17b index, {E_adj, M_lo, S}).
- This block streams table words from a host valid/ready port into those SRAMs: hi table first, then lo table, then a 32-bit checksum trailer.
- It raises table_valid only when the trailer matches. Downstream exp lookups are qualified by table_valid.

Parameters:
- HI_AW, 16, hi table address width (entries = 2^HI_AW)
- LO_AW, 17, lo table address width (entries = 2^LO_AW)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  single-cycle pulse, begins a load
- load_data  in  32  table word / trailer word
- load_valid  in  1  load_data valid
- load_ready  out  1  block accepts load_data this cycle
- hi_we  out  1  hi SRAM write enable
- hi_waddr  out  HI_AW  hi SRAM write address
- hi_wdata  out  32  hi SRAM write data
- lo_we  out  1  lo SRAM write enable
- lo_waddr  out  LO_AW  lo SRAM write address
- lo_wdata  out  32  lo SRAM write data
- busy  out  1  load in progress
- table_valid  out  1  tables loaded and checksum matched
- cksum_err  out  1  last load failed checksum

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: load_ready, hi_we, lo_we, busy, table_valid, cksum_err; addresses, wdata, counter and checksum accumulator also 0.
- Handshake: word accepted iff load_valid && load_ready at a rising edge. load_valid may stay high across cycles; each accepting edge consumes one word.
- States:
  - IDLE: load_ready=0, busy=0. start → LOAD_HI. On that transition: counter=0, accumulator=0, table_valid=0, cksum_err=0.
  - LOAD_HI: load_ready=1, busy=1.
    - Accepted word → accumulator += word (mod 2^32).
    - Registered write on the next cycle: hi_we=1, hi_waddr=counter, hi_wdata=word.
    - counter increments. After the word at counter=2^HI_AW-1: counter wraps to 0, go to LOAD_LO.
  - LOAD_LO: same rules on the lo port. After counter=2^LO_AW-1: go to CHECK.
  - CHECK: load_ready=1, busy=1. Accepted word is the trailer; it is not written and not accumulated.
    - trailer == accumulator → table_valid=1, cksum_err=0.
    - mismatch → table_valid=0, cksum_err=1.
    - Either way → IDLE.
- Write latency: exactly 1 cycle from accept edge to we high. we is high one cycle per accepted word. Never hi_we && lo_we in the same cycle.
- The last lo write and the hi→lo switch need no bubble: back-to-back valid words are accepted every cycle with no stall, so total accept cycles = 2^HI_AW + 2^LO_AW + 1.
- load_valid low: no accept, no write, state and counter hold.
- start while busy: ignored.
- start in IDLE after a completed or failed load: restarts the load and clears table_valid and cksum_err the same edge.
- Reset mid-load: returns to IDLE immediately. table_valid=0, tables considered invalid. Partial SRAM contents are not cleared.
- start and load_valid in the same IDLE cycle: the word is not accepted (load_ready=0 in IDLE). The first accept happens on the following cycle.
- busy deasserts on the cycle after the trailer is accepted. table_valid/cksum_err update on the same edge as the IDLE transition.

Test Plan:
- Use HI_AW=2, LO_AW=3 for all scenarios.
- Nominal: start, then stream 1..12 back-to-back, then trailer 78 (0x4E) → hi writes addr 0..3 with data 1..4; lo writes addr 0..7 with data 5..12; no trailer write; table_valid=1, cksum_err=0, busy=0 after 13 accepts.
- Bad checksum: same stream, trailer 79 → table_valid=0, cksum_err=1, state IDLE. New start clears cksum_err.
- Throttled: load_valid toggling 1,0,1,0 → writes only on cycles after accepts; addresses contiguous 0..3 then 0..7; same final table_valid=1.
- Wrap/sum overflow: all 12 words 0xFFFFFFFF, trailer 0xFFFFFFF4 → table_valid=1, confirming mod-2^32 sum.
- Reset mid-load: assert rst=0 after 6 accepts → all outputs 0 asynchronously. start plus a full valid stream then succeeds from hi addr 0.
- start while busy: pulse start after 3 accepts → ignored; hi addr continues at 3 and the load completes normally.

Source files
------------

// File: rtl/exp_table_loader_if.sv
// Host-to-loader word stream: valid/ready handshake carrying table words
// followed by one checksum trailer word.
interface exp_table_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/exp_table_loader.sv
// Fill stage for the FP32 exp lookup tables. Streams host words into the hi
// SRAM, then the lo SRAM, then checks a 32-bit additive checksum trailer and
// raises table_valid only when it matches.
module exp_table_loader #(
  parameter int HI_AW = 16,
  parameter int LO_AW = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  exp_table_loader_if.slave   load,
  output logic                hi_we,
  output logic [HI_AW-1:0]    hi_waddr,
  output logic [31:0]         hi_wdata,
  output logic                lo_we,
  output logic [LO_AW-1:0]    lo_waddr,
  output logic [31:0]         lo_wdata,
  output logic                busy,
  output logic                table_valid,
  output logic                cksum_err
);

  // One counter serves both tables, so it is as wide as the larger one.
  localparam int CW = (LO_AW > HI_AW) ? LO_AW : HI_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt;
  logic [31:0]    acc;
  logic           ready;
  logic           accept;
  logic           hi_last;
  logic           lo_last;

  // Ready is a pure function of state so the host sees it before the edge.
  assign ready           = (state_q != IDLE);
  assign load.load_ready = ready;
  assign busy            = ready;
  assign accept          = load.load_valid && ready;

  // The counter never exceeds the current table's top entry, so the low
  // slice being all ones marks the last word of that table.
  assign hi_last = &cnt[HI_AW-1:0];
  assign lo_last = &cnt[LO_AW-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: table switches happen on the accepting edge, so no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = LOAD_HI;
      LOAD_HI: if (accept && hi_last)  state_d = LOAD_LO;
      LOAD_LO: if (accept && lo_last)  state_d = CHECK;
      CHECK:   if (accept)             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Accept stage -> registered SRAM write one cycle later; checksum and
  // status flags update on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_we       <= 1'b0;
      hi_waddr    <= '0;
      hi_wdata    <= '0;
      lo_we       <= 1'b0;
      lo_waddr    <= '0;
      lo_wdata    <= '0;
      cnt         <= '0;
      acc         <= '0;
      table_valid <= 1'b0;
      cksum_err   <= 1'b0;
    end else begin
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            acc         <= '0;
            table_valid <= 1'b0;
            cksum_err   <= 1'b0;
          end
        end
        LOAD_HI: begin
          if (accept) begin
            hi_we    <= 1'b1;
            hi_waddr <= cnt[HI_AW-1:0];
            hi_wdata <= load.load_data;
            acc      <= acc + load.load_data;
            cnt      <= hi_last ? '0 : cnt + CW'(1);
          end
        end
        LOAD_LO: begin
          if (accept) begin
            lo_we    <= 1'b1;
            lo_waddr <= cnt[LO_AW-1:0];
            lo_wdata <= load.load_data;
            acc      <= acc + load.load_data;
            cnt      <= lo_last ? '0 : cnt + CW'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            table_valid <= (load.load_data == acc);
            cksum_err   <= (load.load_data != acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_table_loader.sv
// Bench for exp_table_loader with a 4-entry hi table and 8-entry lo table.
// A word-index model predicts every output each cycle; directed scenarios
// add literal expectations, then randomized loads stress the handshake.
module tb_exp_table_loader;
  localparam int HI_AW = 2;
  localparam int LO_AW = 3;
  localparam int NH    = 4;
  localparam int NL    = 8;
  localparam int NW    = NH + NL;

  typedef logic [31:0] words_t [NW];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              hi_we;
  logic [HI_AW-1:0]  hi_waddr;
  logic [31:0]       hi_wdata;
  logic              lo_we;
  logic [LO_AW-1:0]  lo_waddr;
  logic [31:0]       lo_wdata;
  logic              busy;
  logic              table_valid;
  logic              cksum_err;

  exp_table_loader_if #(.DATA_W(32)) lif ();

  exp_table_loader #(.HI_AW(HI_AW), .LO_AW(LO_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load        (lif),
    .hi_we       (hi_we),
    .hi_waddr    (hi_waddr),
    .hi_wdata    (hi_wdata),
    .lo_we       (lo_we),
    .lo_waddr    (lo_waddr),
    .lo_wdata    (lo_wdata),
    .busy        (busy),
    .table_valid (table_valid),
    .cksum_err   (cksum_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int n_hi_wr     = 0;
  int n_lo_wr     = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: position of the next word within the load decides
  // where it goes (0..NH-1 hi, NH..NW-1 lo, NW trailer).
  bit          m_busy;
  int          m_n;
  logic [31:0] m_sum;
  bit          m_tv, m_ce;
  bit          e_hi_we, e_lo_we;
  logic [HI_AW-1:0] e_hi_addr;
  logic [LO_AW-1:0] e_lo_addr;
  logic [31:0] e_hi_data, e_lo_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_n <= 0; m_sum <= '0; m_tv <= 0; m_ce <= 0;
      e_hi_we <= 0; e_lo_we <= 0; e_hi_addr <= '0; e_lo_addr <= '0;
      e_hi_data <= '0; e_lo_data <= '0;
    end else begin
      e_hi_we <= 0;
      e_lo_we <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1; m_n <= 0; m_sum <= '0; m_tv <= 0; m_ce <= 0;
        end
      end else if (lif.load_valid) begin
        if (m_n < NH) begin
          e_hi_we <= 1; e_hi_addr <= HI_AW'(m_n); e_hi_data <= lif.load_data;
          m_sum <= m_sum + lif.load_data;
        end else if (m_n < NW) begin
          e_lo_we <= 1; e_lo_addr <= LO_AW'(m_n - NH); e_lo_data <= lif.load_data;
          m_sum <= m_sum + lif.load_data;
        end else begin
          m_tv <= (lif.load_data == m_sum);
          m_ce <= (lif.load_data != m_sum);
          m_busy <= 0;
        end
        m_n <= m_n + 1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("load_ready",  {31'd0, lif.load_ready}, {31'd0, m_busy});
    chk("busy",        {31'd0, busy},           {31'd0, m_busy});
    chk("hi_we",       {31'd0, hi_we},          {31'd0, e_hi_we});
    chk("hi_waddr",    32'(hi_waddr),           32'(e_hi_addr));
    chk("hi_wdata",    hi_wdata,                e_hi_data);
    chk("lo_we",       {31'd0, lo_we},          {31'd0, e_lo_we});
    chk("lo_waddr",    32'(lo_waddr),           32'(e_lo_addr));
    chk("lo_wdata",    lo_wdata,                e_lo_data);
    chk("table_valid", {31'd0, table_valid},    {31'd0, m_tv});
    chk("cksum_err",   {31'd0, cksum_err},      {31'd0, m_ce});
    if (hi_we) n_hi_wr++;
    if (lo_we) n_lo_wr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input bit overlap, input logic [31:0] w0);
    start = 1'b1;
    if (overlap) begin
      lif.load_valid = 1'b1;
      lif.load_data  = w0;
    end
    step();
    start = 1'b0;
    lif.load_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: alternating valid, 2: random gaps.
  task automatic stream(input words_t w, input logic [31:0] trailer,
                        input int mode, input int start_at);
    for (int i = 0; i <= NW; i++) begin
      lif.load_valid = 1'b1;
      lif.load_data  = (i < NW) ? w[i] : trailer;
      start = (i == start_at);
      step();
      start = 1'b0;
      if (mode != 0) begin
        int gaps;
        gaps = (mode == 1) ? 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          lif.load_valid = 1'b0;
          lif.load_data  = $urandom;
          step();
        end
      end
    end
    lif.load_valid = 1'b0;
  endtask

  words_t nom, ones, rw;
  logic [31:0] rsum, rtrl;

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    for (int i = 0; i < NW; i++) begin
      nom[i]  = 32'(i + 1);
      ones[i] = 32'hFFFF_FFFF;
    end

    // Reset state.
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tv",   {31'd0, table_valid}, 32'd0);
    rst = 1'b1;
    step();

    // Nominal load, 1..12 then trailer 78.
    n_hi_wr = 0; n_lo_wr = 0;
    begin_load(1'b0, '0);
    stream(nom, 32'd78, 0, -1);
    chk("nom_model_sum", m_sum, 32'h4E);
    chk("nom_tv",   {31'd0, table_valid}, 32'd1);
    chk("nom_err",  {31'd0, cksum_err},   32'd0);
    chk("nom_busy", {31'd0, busy},        32'd0);
    step();
    chk("nom_hi_writes", 32'(n_hi_wr), 32'd4);
    chk("nom_lo_writes", 32'(n_lo_wr), 32'd8);
    chk("nom_last_lo_addr", 32'(lo_waddr), 32'd7);
    chk("nom_last_lo_data", lo_wdata, 32'd12);

    // Bad checksum.
    begin_load(1'b0, '0);
    stream(nom, 32'd79, 0, -1);
    chk("bad_tv",  {31'd0, table_valid}, 32'd0);
    chk("bad_err", {31'd0, cksum_err},   32'd1);
    step();
    chk("bad_idle", {31'd0, busy}, 32'd0);

    // New start clears the error; this load is throttled 1,0,1,0.
    begin_load(1'b0, '0);
    chk("restart_err", {31'd0, cksum_err}, 32'd0);
    stream(nom, 32'd78, 1, -1);
    chk("thr_tv", {31'd0, table_valid}, 32'd1);
    step();

    // Sum wraps mod 2^32.
    begin_load(1'b0, '0);
    stream(ones, 32'hFFFF_FFF4, 0, -1);
    chk("wrap_tv", {31'd0, table_valid}, 32'd1);
    step();

    // Reset after 6 accepts.
    begin_load(1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      lif.load_valid = 1'b1;
      lif.load_data  = nom[i];
      step();
    end
    lif.load_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_lo_we",  {31'd0, lo_we},  32'd0);
    chk("arst_busy",   {31'd0, busy},   32'd0);
    chk("arst_ready",  {31'd0, lif.load_ready}, 32'd0);
    chk("arst_lo_addr", 32'(lo_waddr), 32'd0);
    chk("arst_hi_data", hi_wdata, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Start and valid together in IDLE: first word taken on the next cycle.
    begin_load(1'b1, nom[0]);
    stream(nom, 32'd78, 0, -1);
    chk("recover_tv", {31'd0, table_valid}, 32'd1);
    step();

    // Start while busy is ignored.
    begin_load(1'b0, '0);
    stream(nom, 32'd78, 0, 3);
    chk("sbusy_tv", {31'd0, table_valid}, 32'd1);
    step();

    // Randomized loads.
    for (int t = 0; t < 20; t++) begin
      bit good;
      rsum = '0;
      for (int i = 0; i < NW; i++) begin
        rw[i] = $urandom;
        rsum  = rsum + rw[i];
      end
      good = ($urandom_range(0, 2) != 0);
      rtrl = good ? rsum : (rsum ^ (32'd1 << $urandom_range(0, 31)));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        lif.load_valid = 1'($urandom_range(0, 1));
        lif.load_data  = $urandom;
        step();
      end
      begin_load(1'($urandom_range(0, 1)), rw[0]);
      stream(rw, rtrl, int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW)) : -1);
      chk("rnd_tv",  {31'd0, table_valid}, {31'd0, good});
      chk("rnd_err", {31'd0, cksum_err},   {31'd0, !good});
    end
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
